// File: rtl/bit_deserializer.sv
// Serial-to-parallel converter: collects WIDTH accepted bits into a word and
// presents it on a valid/ready output, with flush and a saturating word counter.
module bit_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_bit,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt,
    output logic [15:0]                word_cnt
);

    localparam int unsigned CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [15:0] WC_MAX = 16'hFFFF;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-2:0]   sr;
    logic [WIDTH-2:0]   sr_d;
    logic [WIDTH-1:0]   word_c;
    logic [CW-1:0]      pos;
    logic               accept;
    logic               complete;
    logic               consume;

    // Handshake decode; the last bit of a word stalls only while an unconsumed word blocks it
    always_comb begin
        in_ready = !flush && !((bit_cnt == LAST) && out_valid && !out_ready);
        accept   = in_valid && in_ready;
        complete = accept && (bit_cnt == LAST);
        consume  = out_valid && out_ready;
    end

    // Partial-word storage: sr holds every word bit except the one arriving last
    always_comb begin
        sr_d   = sr;
        pos    = LSB_FIRST ? bit_cnt : (CW'(WIDTH - 2) - bit_cnt);
        word_c = LSB_FIRST ? {in_bit, sr} : {sr, in_bit};
        if (accept && !complete) begin
            for (int unsigned i = 0; i < WIDTH - 1; i++) begin
                if (CW'(i) == pos) begin
                    sr_d[i] = in_bit;
                end
            end
        end
    end

    // Output FSM next-state: a completion always lands in HOLD, a bare consume empties it
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (complete) begin
                    state_d = HOLD;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign out_valid = (state_q == HOLD);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit counter and shift register; flush restarts the partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            sr      <= '0;
        end else begin
            sr <= sr_d;
            if (flush) begin
                bit_cnt <= '0;
            end else if (accept) begin
                bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
            end
        end
    end

    // Output word register, loaded on the edge that accepts the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (complete) begin
            out_data <= word_c;
        end
    end

    // Delivered-word counter, saturating at all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (consume && (word_cnt != WC_MAX)) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: directed scenarios plus random traffic compared
// every cycle against a queue-based model of the word assembly rules.
module tb_bit_deserializer;

    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_bit;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic        in_ready;
    logic [W-1:0] out_data;
    logic        out_valid;
    logic [2:0]  bit_cnt;
    logic [15:0] word_cnt;
    logic        in_ready_m;
    logic [W-1:0] out_data_m;
    logic        out_valid_m;
    logic [2:0]  bit_cnt_m;
    logic [15:0] word_cnt_m;

    int checks = 0;
    int errors = 0;

    // Model state
    bit          q[$];
    logic        m_ov;
    logic [W-1:0] m_dl;
    logic [W-1:0] m_dm;
    logic [15:0] m_wc;

    bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .bit_cnt(bit_cnt),
        .word_cnt(word_cnt)
    );

    bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready_m), .flush(flush), .out_data(out_data_m),
        .out_valid(out_valid_m), .out_ready(out_ready), .bit_cnt(bit_cnt_m),
        .word_cnt(word_cnt_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance the model over the coming edge
    task automatic model_step();
        logic rdy;
        logic cons;
        logic done;
        if (!rst_n) begin
            q.delete();
            m_ov = 1'b0;
            m_dl = '0;
            m_dm = '0;
            m_wc = '0;
        end
        rdy = !flush && !((q.size() == W - 1) && m_ov && !out_ready);
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("in_ready_msb", 32'(in_ready_m), 32'(rdy));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_valid_msb", 32'(out_valid_m), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_dl));
        check("out_data_msb", 32'(out_data_m), 32'(m_dm));
        check("bit_cnt", 32'(bit_cnt), 32'(q.size()));
        check("word_cnt", 32'(word_cnt), 32'(m_wc));
        if (rst_n) begin
            cons = m_ov && out_ready;
            done = 1'b0;
            if (cons && m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            if (flush) begin
                q.delete();
            end else if (in_valid && rdy) begin
                q.push_back(in_bit);
                if (q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        m_dl[i]         = q[i];
                        m_dm[W - 1 - i] = q[i];
                    end
                    q.delete();
                    done = 1'b1;
                end
            end
            if (done) m_ov = 1'b1;
            else if (cons) m_ov = 1'b0;
        end
    endtask

    // One clock: drive inputs just after a rising edge, compare on the falling edge
    task automatic step(input logic v, input logic b, input logic f, input logic r);
        in_valid  = v;
        in_bit    = b;
        flush     = f;
        out_ready = r;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] val, input logic r);
        for (int i = 0; i < 8; i++) step(1'b1, val[i], 1'b0, r);
    endtask

    initial begin
        logic [7:0] seq;
        rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        m_ov = 1'b0; m_dl = '0; m_dm = '0; m_wc = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Bits 1,0,1,0,0,0,0,1 on consecutive cycles
        seq = 8'b1000_0101;
        send_byte(seq, 1'b1);
        check("lsb_word_85", 32'(out_data), 32'h85);
        check("msb_word_a1", 32'(out_data_m), 32'hA1);
        check("word_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("one_cycle_valid", 32'(out_valid), 32'd0);
        check("word_cnt_1", 32'(word_cnt), 32'd1);

        // Backpressure: 0xFF held while 0x0F assembles up to its last bit
        send_byte(8'hFF, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, (i < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_bit = 1'b0; out_ready = 1'b0;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("held_ff", 32'(out_data), 32'hFF);
        check("held_bit_cnt", 32'(bit_cnt), 32'd7);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("replace_0f", 32'(out_data), 32'h0F);
        check("replace_valid", 32'(out_valid), 32'd1);
        check("replace_cnt", 32'(word_cnt), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("drain_cnt", 32'(word_cnt), 32'd3);

        // Flush drops the partial word and the bit presented with it
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("flush_bit_cnt", 32'(bit_cnt), 32'd0);
        send_byte(8'h3C, 1'b1);
        check("after_flush_3c", 32'(out_data), 32'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-word with a pending output word
        send_byte(8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_data", 32'(out_data), 32'd0);
        check("async_bit_cnt", 32'(bit_cnt), 32'd0);
        check("async_word_cnt", 32'(word_cnt), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation of the delivered-word counter
        force dut.word_cnt = 16'hFFFE;
        #2;
        release dut.word_cnt;
        m_wc = 16'hFFFE;
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("word_cnt_sat", 32'(word_cnt), 32'hFFFF);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                step(1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
                rst_n = 1'b1;
            end
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom),
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
